// File: rtl/clk_divider_prog.sv
// Programmable integer clock divider with glitch-free ratio reload, clean stop and edge strobes.
// Optional build macro CLKDIV_DUTY_EN adds a programmable high time (duty_i).
module clk_divider_prog #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_load,
`ifdef CLKDIV_DUTY_EN
  input  logic [CNT_W-1:0] duty_i,
`endif
  output logic             clkout,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             running,
  output logic             load_pending,
  output logic [CNT_W-1:0] div_active
);

  typedef enum logic [1:0] {
    PARK  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  function automatic logic [CNT_W-1:0] sanitise(
    input logic [CNT_W-1:0] d
  );
    return (d < TWO) ? TWO : d;
  endfunction

  function automatic logic [CNT_W-1:0] ceil_half(
    input logic [CNT_W-1:0] d
  );
    return (d >> 1) + {{(CNT_W-1){1'b0}}, d[0]};
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             clkout_q, clkout_d;
  logic [CNT_W-1:0] hl_cur, hl_nxt;
  logic [CNT_W-1:0] last;
  logic             wrap;
  logic             apply;

`ifdef CLKDIV_DUTY_EN
  function automatic logic [CNT_W-1:0] clamp_hl(
    input logic [CNT_W-1:0] duty,
    input logic [CNT_W-1:0] div
  );
    logic [CNT_W-1:0] top;
    top = div - ONE;
    if (duty == '0)     return ONE;
    else if (duty > top) return top;
    else                 return duty;
  endfunction

  logic [CNT_W-1:0] duty_pend_q, duty_pend_d;
  logic [CNT_W-1:0] hl_q, hl_d;
`endif

  assign last = div_cur_q - ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    unique case (state_q)
      PARK: begin
        if (en) begin
          wrap    = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == last) begin
          wrap  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
        if (!en) state_d = DRAIN;
      end
      DRAIN: begin
        if (en) begin
          state_d = RUN;
          if (cnt_q == last) begin
            wrap  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else if (cnt_q == last) begin
          state_d = PARK;
        end else begin
          cnt_d = cnt_q + ONE;
          if (cnt_d == last) state_d = PARK;
        end
      end
      default: state_d = PARK;
    endcase
  end

  // A strobe on the wrap edge itself is applied at once, beating any older pending value.
  assign apply = wrap && (pend_q || div_load);

  always_comb begin
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    if (apply) begin
      div_cur_d = div_load ? sanitise(div_i) : div_pend_q;
      pend_d    = 1'b0;
    end else if (div_load) begin
      div_pend_d = sanitise(div_i);
      pend_d     = 1'b1;
    end
  end

`ifdef CLKDIV_DUTY_EN
  always_comb begin
    duty_pend_d = duty_pend_q;
    hl_d        = hl_q;
    if (apply) begin
      hl_d = clamp_hl(div_load ? duty_i : duty_pend_q, div_cur_d);
    end else if (div_load) begin
      duty_pend_d = duty_i;
    end
  end

  assign hl_cur = hl_q;
  assign hl_nxt = hl_d;
`else
  assign hl_cur = ceil_half(div_cur_q);
  assign hl_nxt = ceil_half(div_cur_d);
`endif

  // PARK holds cnt at div-1, which is never below high_len, so clkout parks low.
  assign clkout_d = (cnt_d < hl_nxt);

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q    <= PARK;
      cnt_q      <= DEF_DIV - ONE;
      div_cur_q  <= DEF_DIV;
      div_pend_q <= DEF_DIV;
      pend_q     <= 1'b0;
      clkout_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      clkout_q   <= clkout_d;
    end
  end

`ifdef CLKDIV_DUTY_EN
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      duty_pend_q <= ceil_half(DEF_DIV);
      hl_q        <= ceil_half(DEF_DIV);
    end else begin
      duty_pend_q <= duty_pend_d;
      hl_q        <= hl_d;
    end
  end
`endif

  assign running      = (state_q != PARK);
  assign rise_tick    = running && (cnt_q == '0);
  assign fall_tick    = running && (cnt_q == hl_cur);
  assign clkout       = clkout_q;
  assign load_pending = pend_q;
  assign div_active   = div_cur_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog: reload timing, stop/drain, sanitising, reset.
// Duty-cycle checks are compiled in when CLKDIV_DUTY_EN is defined.
module tb_clk_divider_prog;

  logic       clkin = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] div_i;
  logic       div_load;
`ifdef CLKDIV_DUTY_EN
  logic [7:0] duty_i;
`endif
  logic       clkout;
  logic       rise_tick;
  logic       fall_tick;
  logic       running;
  logic       load_pending;
  logic [7:0] div_active;

  int n_chk  = 0;
  int n_fail = 0;

  clk_divider_prog #(.CNT_W(8), .DEFAULT_DIV(2)) dut (
    .clkin        (clkin),
    .rst          (rst),
    .en           (en),
    .div_i        (div_i),
    .div_load     (div_load),
`ifdef CLKDIV_DUTY_EN
    .duty_i       (duty_i),
`endif
    .clkout       (clkout),
    .rise_tick    (rise_tick),
    .fall_tick    (fall_tick),
    .running      (running),
    .load_pending (load_pending),
    .div_active   (div_active)
  );

  always #5 clkin = ~clkin;

  // Called at a negedge; strobes one load and returns at the next negedge.
  task automatic do_load(input logic [7:0] d, input logic [7:0] duty);
    div_i    = d;
`ifdef CLKDIV_DUTY_EN
    duty_i   = duty;
`else
    if (duty == 8'hff) div_i = d;
`endif
    div_load = 1'b1;
    @(negedge clkin);
    div_load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; div_i = '0; div_load = 1'b0;
`ifdef CLKDIV_DUTY_EN
    duty_i = '0;
`endif
    repeat (3) @(negedge clkin);
    rst = 1'b0;
    repeat (2) @(negedge clkin);
    n_chk++;
    if (clkout !== 1'b0) begin
      n_fail++; $display("FAIL rst_clkout: got %b want 0", clkout);
    end
    n_chk++;
    if (running !== 1'b0) begin
      n_fail++; $display("FAIL rst_running: got %b want 0", running);
    end
    n_chk++;
    if ({rise_tick, fall_tick, load_pending} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_flags: got %b want 000",
               {rise_tick, fall_tick, load_pending});
    end
    n_chk++;
    if (div_active !== 8'd2) begin
      n_fail++; $display("FAIL rst_div: got %0d want 2", div_active);
    end
  endtask

  task automatic test_default_ratio;
    logic e;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clkin);
      e = (i % 2 == 0);
      n_chk++;
      if (clkout !== e || rise_tick !== e || fall_tick !== !e) begin
        n_fail++;
        $display("FAIL dflt_cyc%0d: got clk=%b rise=%b fall=%b want %b %b %b",
                 i, clkout, rise_tick, fall_tick, e, e, !e);
      end
    end
    n_chk++;
    if (div_active !== 8'd2 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL dflt_div: got div=%0d run=%b want 2 1", div_active, running);
    end
  endtask

  task automatic test_load_apply;
    logic e;
    @(negedge clkin);
    do_load(8'd5, 8'd3);
    n_chk++;
    if (load_pending !== 1'b1 || div_active !== 8'd2 || clkout !== 1'b0) begin
      n_fail++;
      $display("FAIL ld5_pend: got pend=%b div=%0d clk=%b want 1 2 0",
               load_pending, div_active, clkout);
    end
    @(negedge clkin);
    n_chk++;
    if (load_pending !== 1'b0 || div_active !== 8'd5) begin
      n_fail++;
      $display("FAIL ld5_apply: got pend=%b div=%0d want 0 5",
               load_pending, div_active);
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clkin);
      e = ((i % 5) < 3);
      n_chk++;
      if (clkout !== e || fall_tick !== (i % 5 == 3)) begin
        n_fail++;
        $display("FAIL ld5_cyc%0d: got clk=%b fall=%b want %b %b",
                 i, clkout, fall_tick, e, (i % 5 == 3));
      end
    end
  endtask

  task automatic test_last_load_wins;
    do_load(8'd10, 8'd5);
    n_chk++;
    if (div_active !== 8'd10 || load_pending !== 1'b0 || clkout !== 1'b1) begin
      n_fail++;
      $display("FAIL ld_on_wrap: got div=%0d pend=%b clk=%b want 10 0 1",
               div_active, load_pending, clkout);
    end
    do_load(8'd6, 8'd3);
    n_chk++;
    if (load_pending !== 1'b1 || div_active !== 8'd10) begin
      n_fail++;
      $display("FAIL ld6_pend: got pend=%b div=%0d want 1 10",
               load_pending, div_active);
    end
    @(negedge clkin);
    do_load(8'd4, 8'd2);
    for (int c = 3; c < 10; c++) begin
      n_chk++;
      if (div_active !== 8'd10) begin
        n_fail++; $display("FAIL ld_hold_c%0d: got %0d want 10", c, div_active);
      end
      @(negedge clkin);
    end
    n_chk++;
    if (div_active !== 8'd4 || load_pending !== 1'b0 || clkout !== 1'b1) begin
      n_fail++;
      $display("FAIL ld_last_wins: got div=%0d pend=%b clk=%b want 4 0 1",
               div_active, load_pending, clkout);
    end
  endtask

  task automatic test_stop_drain;
    logic ok;
    logic ec, er, ef;
    do_load(8'd8, 8'd4);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (div_active === 8'd8) begin ok = 1'b1; break; end
      @(negedge clkin);
    end
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL stop_wait8: got %0d want 8", div_active);
    end
    @(negedge clkin);
    en = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clkin);
      ec = (j < 2);
      er = (j < 5);
      ef = (j == 2);
      n_chk++;
      if (clkout !== ec || running !== er || fall_tick !== ef ||
          rise_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_j%0d: got clk=%b run=%b fall=%b rise=%b want %b %b %b 0",
                 j, clkout, running, fall_tick, rise_tick, ec, er, ef);
      end
    end
    en = 1'b1;
    @(negedge clkin);
    n_chk++;
    if (clkout !== 1'b1 || running !== 1'b1 || rise_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: got clk=%b run=%b rise=%b want 1 1 1",
               clkout, running, rise_tick);
    end
  endtask

  task automatic test_sanitise;
    logic ok;
    do_load(8'd0, 8'd1);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (div_active === 8'd2) begin ok = 1'b1; break; end
      @(negedge clkin);
    end
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL san0_div: got %0d want 2", div_active);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clkin);
      n_chk++;
      if (clkout !== (i % 2 == 0)) begin
        n_fail++;
        $display("FAIL san0_cyc%0d: got %b want %b", i, clkout, (i % 2 == 0));
      end
    end
    do_load(8'd3, 8'd2);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (div_active === 8'd3) begin ok = 1'b1; break; end
      @(negedge clkin);
    end
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL san_div3: got %0d want 3", div_active);
    end
    do_load(8'd1, 8'd1);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (div_active === 8'd2) begin ok = 1'b1; break; end
      @(negedge clkin);
    end
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL san1_div: got %0d want 2", div_active);
    end
    @(negedge clkin);
    n_chk++;
    if (clkout !== 1'b0 || fall_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL san1_low: got clk=%b fall=%b want 0 1", clkout, fall_tick);
    end
  endtask

  task automatic test_max_ratio;
    logic ok;
    int hi, lo, rs, fs;
    do_load(8'd255, 8'd128);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (div_active === 8'd255) begin ok = 1'b1; break; end
      @(negedge clkin);
    end
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL max_div: got %0d want 255", div_active);
    end
    hi = 0; lo = 0; rs = 0; fs = 0;
    for (int i = 0; i < 255; i++) begin
      if (i > 0) @(negedge clkin);
      if (clkout === 1'b1) hi++; else lo++;
      if (rise_tick === 1'b1) rs++;
      if (fall_tick === 1'b1) fs++;
    end
    n_chk++;
    if (hi != 128 || lo != 127) begin
      n_fail++; $display("FAIL max_duty: got hi=%0d lo=%0d want 128 127", hi, lo);
    end
    n_chk++;
    if (rs != 1 || fs != 1) begin
      n_fail++; $display("FAIL max_ticks: got rise=%0d fall=%0d want 1 1", rs, fs);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clkin);
    do_load(8'd7, 8'd4);
    n_chk++;
    if (load_pending !== 1'b1 || clkout !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre: got pend=%b clk=%b want 1 1", load_pending, clkout);
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (clkout !== 1'b0 || load_pending !== 1'b0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async: got clk=%b pend=%b run=%b want 0 0 0",
               clkout, load_pending, running);
    end
    en = 1'b0;
    @(negedge clkin);
    rst = 1'b0;
    @(negedge clkin);
    n_chk++;
    if (running !== 1'b0 || clkout !== 1'b0 || load_pending !== 1'b0 ||
        div_active !== 8'd2) begin
      n_fail++;
      $display("FAIL rmid_post: got run=%b clk=%b pend=%b div=%0d want 0 0 0 2",
               running, clkout, load_pending, div_active);
    end
  endtask

  task automatic test_park_load;
    do_load(8'd5, 8'd3);
    @(negedge clkin);
    n_chk++;
    if (load_pending !== 1'b1 || div_active !== 8'd2 || clkout !== 1'b0 ||
        running !== 1'b0) begin
      n_fail++;
      $display("FAIL park_hold: got pend=%b div=%0d clk=%b run=%b want 1 2 0 0",
               load_pending, div_active, clkout, running);
    end
    en = 1'b1;
    @(negedge clkin);
    n_chk++;
    if (load_pending !== 1'b0 || div_active !== 8'd5 || clkout !== 1'b1 ||
        rise_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL park_apply: got pend=%b div=%0d clk=%b rise=%b want 0 5 1 1",
               load_pending, div_active, clkout, rise_tick);
    end
  endtask

`ifdef CLKDIV_DUTY_EN
  task automatic test_duty;
    logic ok;
    do_load(8'd6, 8'd1);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (div_active === 8'd6) begin ok = 1'b1; break; end
      @(negedge clkin);
    end
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL duty_div6: got %0d want 6", div_active);
    end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clkin);
      n_chk++;
      if (clkout !== (i < 1)) begin
        n_fail++; $display("FAIL duty1_cyc%0d: got %b want %b", i, clkout, (i < 1));
      end
    end
    do_load(8'd6, 8'd9);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clkin);
      n_chk++;
      if (clkout !== (i < 5)) begin
        n_fail++; $display("FAIL duty9_cyc%0d: got %b want %b", i, clkout, (i < 5));
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_default_ratio;
    test_load_apply;
    test_last_load_wins;
    test_stop_drain;
    test_sanitise;
    test_max_ratio;
    test_reset_mid;
    test_park_load;
`ifdef CLKDIV_DUTY_EN
    test_duty;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
- Runtime-programmable integer clock divider.
- Generates `clkout` with a period of N `clkin` cycles. N is loaded through a load strobe and takes effect only at a period boundary, so `clkout` never glitches.
- Provides clean start/stop: on stop, `clkout` parks low after finishing its current period.
- Provides one-cycle edge strobes so synchronous logic in the `clkin` domain can use the divided clock as an enable instead of a real clock.

Parameters:
CNT_W, 8, width of ratio and counter; max ratio 2^CNT_W-1
DEFAULT_DIV, 2, ratio after reset; must be 2..2^CNT_W-1

Ports:
clkin  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  run request
div_i  in  CNT_W  requested ratio; sampled when div_load=1
div_load  in  1  one-cycle strobe capturing div_i
clkout  out  1  divided clock, registered
rise_tick  out  1  high during the first high clkin cycle of each clkout period
fall_tick  out  1  high during the first low clkin cycle of each clkout period
running  out  1  high in RUN or DRAIN
load_pending  out  1  a captured ratio awaits its period boundary
div_active  out  CNT_W  ratio currently in effect

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=PARK, cnt=DEFAULT_DIV-1, div_cur=DEFAULT_DIV.
  - clkout=0, load_pending=0, running=0, rise_tick=0, fall_tick=0.
- Sanitisation: div_i of 0 or 1 is treated as 2. No other clamping is applied.
- Duty cycle: high_len = ceil(div_cur/2).
  - clkout is a register that always equals (cnt < high_len).
  - An odd N gives one extra high cycle, e.g. N=5 gives 3 high and 2 low.
- Counter: in RUN/DRAIN, cnt steps 0..div_cur-1 and wraps to 0. Outside those states, cnt holds.
- Wrap edge: the clkin edge taking cnt from div_cur-1 to 0.
- Ticks are decodes of registered state, not extra registers:
  - rise_tick = running & (cnt==0).
  - fall_tick = running & (cnt==high_len).
- State machine:
  - PARK: cnt=div_cur-1, clkout=0. If en=1, the next edge is a wrap edge and the state goes to RUN.
  - RUN: counts. If en=0, go to DRAIN on the same edge; counting continues.
  - DRAIN: counts. If en=1, return to RUN with no disturbance to clkout. When cnt reaches div_cur-1 with en=0, go to PARK and hold.
  - First clkout rising edge after leaving PARK: exactly 1 clkin cycle after the edge that sampled en=1.
- Load:
  - div_load=1 captures sanitised div_i into div_pend and sets load_pending.
  - Multiple loads before a boundary: the last one wins.
- Apply: on each wrap edge, if load_pending or div_load is set that cycle:
  - div_cur takes the newest value; div_load beats the old pending value.
  - load_pending clears.
  - cnt=0 and the new high_len applies from that cycle.
- Load in PARK: held pending and applied at the PARK->RUN wrap. div_active keeps the old value until then.
- Simultaneous en drop and wrap edge in RUN: the wrap happens, the state goes to DRAIN, and a pending load is applied.
- Reset mid-period: clkout drops to 0 immediately and pending loads are discarded.

Optional Feature:
Macro: CLKDIV_DUTY_EN
- Defined:
  - Adds input duty_i [CNT_W], captured together with div_i on div_load and applied at the same wrap edge.
  - high_len = duty_i clamped to the range 1..div_cur-1.
  - Reset high_len = ceil(DEFAULT_DIV/2).
- Undefined: port absent; high_len = ceil(div_cur/2).

Test Plan:
- Reset release, en=1 held, default ratio 2 -> clkout toggles every clkin cycle (1 high, 1 low); rise_tick on every high cycle; div_active=2.
- Load div_i=5 at cnt=0 -> ratio stays 2 until the next wrap edge, then period is 5 (3 high, 2 low); load_pending high exactly from the load edge to the wrap edge.
- Loads of 6 then 4 within one period at ratio 10 -> only 4 is applied at the wrap; 6 never appears on div_active.
- en dropped at cnt=1 with ratio 8 -> clkout completes the period (high to cnt=3, low to cnt=7), parks low; running falls on entry to PARK; no further ticks. Re-assert en -> clkout high 1 cycle later.
- div_i=0 and div_i=1 loaded -> both behave as ratio 2. div_i=255 with CNT_W=8 -> 128 high, 127 low.
- rst asserted mid-high period with a load pending -> clkout=0 asynchronously. After release: state PARK, load_pending=0, div_active=DEFAULT_DIV.
- With CLKDIV_DUTY_EN: div=6, duty=1 gives 1 high, 5 low; duty=9 is clamped to 5 high, 1 low.
